// File: rtl/mux_scan_pkg.sv
// Shared definitions for the N-channel scanning multiplexer.
package mux_scan_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_MANUAL  = 2'b00,
        MODE_SCAN_UP = 2'b01,
        MODE_SCAN_DN = 2'b10,
        MODE_FREEZE  = 2'b11
    } mode_e;

endpackage

// File: rtl/mux_scan_n_if.sv
// Channel data, select/mode controls and registered status outputs of mux_scan_n.
interface mux_scan_n_if
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned SEL_W = $clog2(N_CH)
) ();

    logic [N_CH*W-1:0] in;
    logic [SEL_W-1:0]  sel;
    mode_e             mode;
    logic [W-1:0]      out;
    logic [SEL_W-1:0]  cur_ch;
    logic              ch_change;
    logic              sel_err;
    logic [N_CH-1:0]   led;

    modport master (
        output in, sel, mode,
        input  out, cur_ch, ch_change, sel_err, led
    );

    modport slave (
        input  in, sel, mode,
        output out, cur_ch, ch_change, sel_err, led
    );

endinterface

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell timer: counts 0..DWELL-1 while enabled, tc flags the last cycle of a dwell.
module dwell_counter #(
    parameter int unsigned DWELL = 50_000_000,
    localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == CNT_W'(DWELL - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || !en || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N:1 multiplexer with manual select, timed up/down channel scanning and freeze.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 50_000_000,
    localparam int unsigned SEL_W = $clog2(N_CH)
) (
    input logic         clk,
    input logic         rst,
    mux_scan_n_if.slave bus
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] cur_ch_q, next_ch;
    logic [W-1:0]     out_q, out_d;
    logic [N_CH-1:0]  led_q, led_d;
    logic             ch_change_q;
    logic             sel_err_q, sel_err_d;
    mode_e            mode_q;
    logic             scan, mode_chg, tc, step;

    assign scan     = (bus.mode == MODE_SCAN_UP) || (bus.mode == MODE_SCAN_DN);
    assign mode_chg = (bus.mode != mode_q);
    // A mode change in the terminal-count cycle suppresses the step.
    assign step     = tc && !mode_chg;

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk(clk),
        .rst(rst),
        .en (scan),
        .clr(mode_chg),
        .tc (tc)
    );

    always_comb begin
        next_ch   = cur_ch_q;
        sel_err_d = 1'b0;
        unique case (bus.mode)
            MODE_MANUAL: begin
                if (32'(bus.sel) < N_CH) next_ch = bus.sel;
                else                     sel_err_d = 1'b1;
            end
            MODE_SCAN_UP: begin
                if (step) next_ch = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + SEL_W'(1);
            end
            MODE_SCAN_DN: begin
                if (step) next_ch = (cur_ch_q == '0) ? LAST_CH : cur_ch_q - SEL_W'(1);
            end
            MODE_FREEZE: next_ch = cur_ch_q;
            default:     next_ch = cur_ch_q;
        endcase
    end

    // next_ch never exceeds N_CH-1, so only defined slices are reachable.
    always_comb begin
        out_d = '0;
        led_d = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (next_ch == SEL_W'(c)) out_d = bus.in[c*W +: W];
            led_d[c] = (next_ch == SEL_W'(c));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_MANUAL;
            cur_ch_q    <= '0;
            out_q       <= '0;
            led_q       <= N_CH'(1);
            ch_change_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            mode_q      <= bus.mode;
            cur_ch_q    <= next_ch;
            led_q       <= led_d;
            ch_change_q <= (next_ch != cur_ch_q);
            sel_err_q   <= sel_err_d;
            if (bus.mode != MODE_FREEZE) out_q <= out_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.led       = led_q;
    assign bus.ch_change = ch_change_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised N-channel, W-bit registered multiplexer with manual, auto-scan (up/down) and freeze modes. It generalises the board-level 4:1 selector: any channel count, multi-bit channels, clocked output, and timed round-robin channel stepping. It sits between switch/sensor inputs and the LED/display path, and drives a one-hot channel indicator for the LEDs.

## Interface
Parameters:
- N_CH, 8: number of input channels, ≥2, need not be a power of two.
- W, 1: bits per channel.
- DWELL, 50_000_000: clock cycles per channel in scan modes (1 s at 50 MHz), ≥1.
- SEL_W, $clog2(N_CH): derived, not overridden.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in, input, N_CH*W: channel c occupies bits [c*W +: W].
- sel, input, SEL_W: manual channel select.
- mode, input, 2: 00 MANUAL, 01 SCAN_UP, 10 SCAN_DN, 11 FREEZE.
- out, output, W: registered selected channel data.
- cur_ch, output, SEL_W: registered current channel index.
- ch_change, output, 1: one-cycle pulse when cur_ch changes value.
- sel_err, output, 1: one-cycle pulse on an out-of-range sel in MANUAL.
- led, output, N_CH: one-hot copy of cur_ch.

## Operation
- Mode is sampled every cycle. There is no separate state register; the active mode is the state.
- next_ch is computed per mode:
  - MANUAL: next_ch = sel if sel < N_CH. Otherwise next_ch = cur_ch and sel_err pulses.
  - SCAN_UP: when the dwell counter reaches DWELL-1, next_ch = cur_ch+1, wrapping N_CH-1 → 0. Otherwise it holds.
  - SCAN_DN: as SCAN_UP but decrementing, wrapping 0 → N_CH-1.
  - FREEZE: next_ch = cur_ch.
- Register updates each cycle: cur_ch ← next_ch, out ← in slice of next_ch, led ← one-hot(next_ch).
- In FREEZE, out is not updated even if in changes.
- ch_change ← (next_ch ≠ cur_ch).
- Dwell counter:
  - Counts 0..DWELL-1 only in scan modes.
  - Clears on terminal count, on any mode change, and in MANUAL/FREEZE.
  - DWELL=1 steps every cycle.
- Mode changes:
  - MANUAL → scan starts from the current cur_ch; the first step occurs DWELL cycles later.
  - Scan → FREEZE holds channel and data. FREEZE → scan restarts the full dwell.
  - SCAN_UP ↔ SCAN_DN: counter restarts and direction takes effect at the next terminal count.
- Undefined in/sel bits are never selected; slices are only indexed with values < N_CH.

## Timing
- Reset (async assert, sync-safe deassert by the system): cur_ch=0, out=0, led=1 (bit 0), ch_change=0, sel_err=0, counter=0.
- Latency: sel or in change → out/cur_ch/led at the next rising edge (1 cycle). ch_change and sel_err fire on the same edge.
- Scan period: exactly DWELL cycles between consecutive ch_change pulses while the mode is held.
- Reset mid-scan: all outputs return to reset values immediately; scanning resumes from channel 0 with a full dwell after deassert.
- Simultaneous terminal count and mode change: the mode change wins; no step occurs and the counter clears.

## Structure
- Shared package mux_scan_pkg holds:
  - the mode enum (MODE_MANUAL, MODE_SCAN_UP, MODE_SCAN_DN, MODE_FREEZE);
  - the 2-bit mode width constant.
- One sub-module, dwell_counter: parameter DWELL; inputs clk, rst, en, clr; output tc.
- The top handles the channel logic, slice select and one-hot decode.

## Test plan
- MANUAL, N_CH=8, W=4, in channel c = c+3: sel 0→5 → out=8, cur_ch=5, led=8'b0010_0000, one ch_change pulse, all one cycle later.
- SCAN_UP, N_CH=5, DWELL=4 from ch 3 → ch 4 after 4 cycles, then ch 0 after 4 more; ch_change pulses exactly every 4 cycles.
- SCAN_DN, N_CH=5, DWELL=4 from ch 0 → ch 4 after 4 cycles (wrap), then ch 3.
- FREEZE on ch 2, then toggle in channel 2 data → out, cur_ch and led unchanged, no ch_change.
- MANUAL, N_CH=5, sel=6 → sel_err pulses one cycle; cur_ch and out hold; sel=2 then selects normally.
- Assert rst for 1 cycle mid-scan on ch 3 → outputs at reset values immediately; after deassert, first step to ch 1 occurs DWELL cycles later.
